keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_tick.sv | 27 ++
 rtl/keypad_scan.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared FSM state encoding, key map and row-drive constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [3:0] ROW_INIT = 4'b1110;

    // Indexed by {row_idx, col_idx}; rows read 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic one_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    // Position of the single low bit; only meaningful when one_low(v) holds.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        case (v)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/keypad_tick.sv
// Row-slot timer: counts 0..SCAN_DIV-1 and flags the last cycle of each slot.
module keypad_tick #(
    parameter int unsigned SCAN_DIV = 25000
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end_c
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign slot_end_c = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce, valid/ready key handoff and sticky overflow.
// Optional KEYPAD_ENTRY_EN adds a 32-bit hex-entry shift register on the entry port.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 25000,
    parameter int unsigned DEB_CNT  = 20
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        overflow,
    input  logic        clr,
    output logic [31:0] entry
);

    localparam int unsigned DEB_W = 8;
    localparam logic [DEB_W-1:0] DEB_LIM = DEB_W'(DEB_CNT);

    logic             slot_end_c;
    logic [3:0]       col_meta;
    logic [3:0]       col_sync;
    state_t           state,   state_nxt;
    logic [3:0]       row_nxt;
    logic [DEB_W-1:0] deb_cnt, deb_nxt, deb_inc;
    logic [1:0]       row_idx, row_idx_nxt;
    logic [1:0]       col_idx, col_idx_nxt;
    logic [3:0]       pattern, pattern_nxt;
    logic             publish_c;
    logic             drop_c;
    logic [3:0]       pub_code;

    keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .slot_end_c (slot_end_c)
    );

    // Column inputs are asynchronous to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_SCAN;
            row     <= ROW_INIT;
            deb_cnt <= '0;
            row_idx <= '0;
            col_idx <= '0;
            pattern <= 4'hF;
        end else begin
            state   <= state_nxt;
            row     <= row_nxt;
            deb_cnt <= deb_nxt;
            row_idx <= row_idx_nxt;
            col_idx <= col_idx_nxt;
            pattern <= pattern_nxt;
        end
    end

    assign deb_inc = deb_cnt + DEB_W'(1);

    // All decisions are taken only on the slot-end sample.
    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        deb_nxt     = deb_cnt;
        row_idx_nxt = row_idx;
        col_idx_nxt = col_idx;
        pattern_nxt = pattern;
        publish_c   = 1'b0;
        if (slot_end_c) begin
            case (state)
                ST_SCAN: begin
                    if (one_low(col_sync)) begin
                        row_idx_nxt = low_index(row);
                        col_idx_nxt = low_index(col_sync);
                        pattern_nxt = col_sync;
                        deb_nxt     = '0;
                        state_nxt   = ST_DEBOUNCE;
                    end else begin
                        row_nxt = {row[2:0], row[3]};
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_sync != pattern) begin
                        deb_nxt   = '0;
                        state_nxt = ST_SCAN;
                    end else if (deb_inc == DEB_LIM) begin
                        deb_nxt   = '0;
                        publish_c = 1'b1;
                        state_nxt = ST_HELD;
                    end else begin
                        deb_nxt = deb_inc;
                    end
                end
                ST_HELD: begin
                    if (col_sync == 4'hF) begin
                        deb_nxt   = '0;
                        state_nxt = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (col_sync != 4'hF) begin
                        state_nxt = ST_HELD;
                    end else if (deb_inc == DEB_LIM) begin
                        deb_nxt   = '0;
                        state_nxt = ST_SCAN;
                    end else begin
                        deb_nxt = deb_inc;
                    end
                end
                default: state_nxt = ST_SCAN;
            endcase
        end
    end

    assign pub_code = KEY_MAP[{row_idx, col_idx}];
    assign drop_c   = publish_c && key_valid && !key_ready;

    // A publish in the accepting cycle reloads instead of letting key_valid drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (publish_c && (!key_valid || key_ready)) begin
                key_code  <= pub_code;
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_ENTRY_EN
    logic [31:0] entry_q;

    // Dropped keys are still recorded in the entry history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '0;
        end else if (clr) begin
            entry_q <= '0;
        end else if (publish_c) begin
            entry_q <= {entry_q[27:0], pub_code};
        end
    end

    assign entry = entry_q;
`else
    assign entry = '0;
`endif

endmodule
